// File: rtl/dlx_bus_arbiter.sv
// Four-source round-robin bus arbiter with one turnaround cycle between owners.
// Define DLX_ARB_HOLD_LIMIT_EN to cap each ownership at MAX_HOLD cycles.
module dlx_bus_arbiter #(
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    grant,
  output logic [1:0]    grant_id,
  output logic          bus_valid,
  output logic [DW-1:0] bus_out
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] grant_reg, grant_next;
  logic [1:0] id_reg, id_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] pick_id;
  logic       hold_hit;

`ifdef DLX_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt_reg, hold_cnt_next;

  assign hold_hit = (hold_cnt_reg == 8'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= 8'd0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (state_reg == IDLE) begin
      hold_cnt_next = (|req) ? 8'd1 : 8'd0;
    end else if (!req[id_reg] || hold_hit) begin
      hold_cnt_next = 8'd0;
    end else if (hold_cnt_reg != 8'hFF) begin
      hold_cnt_next = hold_cnt_reg + 8'd1;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // Scan from the highest rotation offset down so the nearest requester at or after ptr wins.
  always_comb begin
    pick_id = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_reg + 2'(k)]) begin
        pick_id = ptr_reg + 2'(k);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        grant_next = 4'b0000;
        id_next    = 2'd0;
        if (|req) begin
          state_next = OWN;
          grant_next = 4'b0001 << pick_id;
          id_next    = pick_id;
        end
      end
      OWN: begin
        // A release and a hold-limit hit on the same edge collapse into one handover.
        if (!req[id_reg] || hold_hit) begin
          state_next = IDLE;
          grant_next = 4'b0000;
          id_next    = 2'd0;
          ptr_next   = id_reg + 2'd1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        id_next    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= 4'b0000;
      id_reg    <= 2'd0;
      ptr_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

  logic [DW-1:0] din_arr [4];
  logic [DW-1:0] gated   [4];

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;
  assign din_arr[3] = din3;

  for (genvar gi = 0; gi < 4; gi++) begin : g_gate
    assign gated[gi] = din_arr[gi] & {DW{grant_reg[gi]}};
  end

  assign bus_out   = gated[0] | gated[1] | gated[2] | gated[3];
  assign grant     = grant_reg;
  assign grant_id  = id_reg;
  assign bus_valid = |grant_reg;

endmodule

// File: tb/tb_dlx_bus_arbiter.sv
// Scoreboard bench for dlx_bus_arbiter; expectations follow DLX_ARB_HOLD_LIMIT_EN with MAX_HOLD=3.
module tb_dlx_bus_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] din0, din1, din2, din3;
  logic [3:0]    grant;
  logic [1:0]    grant_id;
  logic          bus_valid;
  logic [DW-1:0] bus_out;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  dlx_bus_arbiter #(.DW(DW), .MAX_HOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .grant(grant), .grant_id(grant_id), .bus_valid(bus_valid), .bus_out(bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_id(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_bus(input logic [3:0] g);
    logic [DW-1:0] v;
    v = '0;
    if (g[0]) v = v | din0;
    if (g[1]) v = v | din1;
    if (g[2]) v = v | din2;
    if (g[3]) v = v | din3;
    return v;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst_n = 1'b0;
    req   = 4'b1111;
    exp_q.push_back(4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_id, bus_valid, bus_out} !== {e, 2'd0, 1'b0, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL reset grant=%b id=%0d valid=%b bus=%h required grant=%b id=0 valid=0 bus=0",
               grant, grant_id, bus_valid, bus_out, e);
    end
    $display("reset: grant=%b bus=%h", grant, bus_out);
  endtask

  task automatic test_single();
    logic [3:0] rq [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
`ifdef DLX_ARB_HOLD_LIMIT_EN
    logic [3:0] ex [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
`else
    logic [3:0] ex [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
`endif
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_id, bus_valid, bus_out} !== {e, exp_id(e), |e, exp_bus(e)}) begin
        errors++;
        $display("FAIL single[%0d] grant=%b id=%0d valid=%b bus=%h required grant=%b id=%0d valid=%b bus=%h",
                 i, grant, grant_id, bus_valid, bus_out, e, exp_id(e), |e, exp_bus(e));
      end
      $display("single[%0d]: req=%b grant=%b bus=%h", i, rq[i], grant, bus_out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rq [14] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
                            4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b1110};
    logic [3:0] ex [14] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                            4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_id, bus_valid, bus_out} !== {e, exp_id(e), |e, exp_bus(e)}) begin
        errors++;
        $display("FAIL round_robin[%0d] grant=%b id=%0d valid=%b bus=%h required grant=%b id=%0d valid=%b bus=%h",
                 i, grant, grant_id, bus_valid, bus_out, e, exp_id(e), |e, exp_bus(e));
      end
      $display("round_robin[%0d]: req=%b grant=%b", i, rq[i], grant);
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] rq [10] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                            4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
`ifdef DLX_ARB_HOLD_LIMIT_EN
    logic [3:0] ex [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                            4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
`else
    logic [3:0] ex [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
`endif
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_id, bus_valid, bus_out} !== {e, exp_id(e), |e, exp_bus(e)}) begin
        errors++;
        $display("FAIL hold_limit[%0d] grant=%b id=%0d valid=%b bus=%h required grant=%b id=%0d valid=%b bus=%h",
                 i, grant, grant_id, bus_valid, bus_out, e, exp_id(e), |e, exp_bus(e));
      end
      $display("hold_limit[%0d]: req=%b grant=%b", i, rq[i], grant);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] rq [9] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011,
                           4'b0110, 4'b1011, 4'b0010, 4'b0000};
`ifdef DLX_ARB_HOLD_LIMIT_EN
    logic [3:0] ex [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                           4'b0010, 4'b0010, 4'b0000, 4'b0000};
`else
    logic [3:0] ex [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                           4'b0010, 4'b0010, 4'b0010, 4'b0000};
`endif
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      req = rq[i];
      exp_q.push_back(ex[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_id, bus_valid, bus_out} !== {e, exp_id(e), |e, exp_bus(e)}) begin
        errors++;
        $display("FAIL simultaneous[%0d] grant=%b id=%0d valid=%b bus=%h required grant=%b id=%0d valid=%b bus=%h",
                 i, grant, grant_id, bus_valid, bus_out, e, exp_id(e), |e, exp_bus(e));
      end
      $display("simultaneous[%0d]: req=%b grant=%b", i, rq[i], grant);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      req = 4'b0100;
      exp_q.push_back(4'b0100);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_id, bus_valid, bus_out} !== {e, exp_id(e), |e, exp_bus(e)}) begin
        errors++;
        $display("FAIL reset_mid_own[%0d] grant=%b id=%0d bus=%h required grant=%b id=%0d bus=%h",
                 i, grant, grant_id, bus_out, e, exp_id(e), exp_bus(e));
      end
      $display("reset_mid_own[%0d]: grant=%b bus=%h", i, grant, bus_out);
    end
    // Pull reset between edges; outputs must clear before the next clock edge.
    #2;
    rst_n = 1'b0;
    exp_q.push_back(4'b0000);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_id, bus_valid, bus_out} !== {e, 2'd0, 1'b0, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_async grant=%b id=%0d valid=%b bus=%h required all zero",
               grant, grant_id, bus_valid, bus_out);
    end
    $display("reset_async: grant=%b bus=%h", grant, bus_out);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_id, bus_valid, bus_out} !== {e, exp_id(e), |e, exp_bus(e)}) begin
      errors++;
      $display("FAIL reset_release grant=%b id=%0d bus=%h required grant=%b id=%0d bus=%h",
               grant, grant_id, bus_out, e, exp_id(e), exp_bus(e));
    end
    $display("reset_release: grant=%b bus=%h", grant, bus_out);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din0  = 32'hDEADBEEF;
    din1  = 32'h12345678;
    din2  = 32'hA5A50F0F;
    din3  = 32'h0000F00D;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_limit();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
